sdram_ctrl_if_gen: RTL

//  Parametrised front end of the SDRAM controller; sits between the host command port and the SDRAM command FSM.

---
 rtl/sdram_ctrl_if_gen.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_ctrl_if_gen.sv
// sdram_ctrl_if_gen: front end of the SDRAM controller.
// It registers and decodes host commands and acknowledges them to the host.
// It sequences power-up init: wait, PRECHARGE, N x REFRESH, then LOAD_MODE.
// It also runs the periodic refresh timer and tracks the refreshes still owed.
// Optional feature macro: REF_POSTPONE_EN.
//   Defined:   owed refreshes build up in a saturating counter (up to MAX_PEND).
//   Undefined: a single flag records the owed refresh, and REF_ACK reloads the timer.
module sdram_ctrl_if_gen #(
    parameter int  ASIZE     = 23,
    parameter int  INIT_PER  = 24000,
    parameter int  INIT_STEP = 20,
    parameter int  INIT_REFS = 8,
    parameter int  REF_PER   = 1024,
    parameter int  MAX_PEND  = 8,
    localparam int PW        = $clog2(MAX_PEND + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [2:0]       CMD,
    input  logic [ASIZE-1:0] ADDR,
    input  logic             REF_ACK,
    input  logic             INIT_ACK,
    input  logic             CM_ACK,
    output logic             NOP,
    output logic             READA,
    output logic             WRITEA,
    output logic             REFRESH,
    output logic             PRECHARGE,
    output logic             LOAD_MODE,
    output logic [ASIZE-1:0] SADDR,
    output logic             REF_REQ,
    output logic [PW-1:0]    REF_PEND,
    output logic             REF_URGENT,
    output logic             INIT_REQ,
    output logic             INIT_DONE,
    output logic             CMD_ACK
);

    localparam int WW = $clog2(INIT_PER + 1);
    localparam int SW = $clog2(INIT_STEP + 1);
    localparam int RW = $clog2(INIT_REFS + 1);
    localparam int TW = $clog2(REF_PER + 1);

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_PRE  = 3'd1,
        S_REF  = 3'd2,
        S_LMR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [SW-1:0]    step_cnt_q, step_cnt_d;
    logic [RW-1:0]    ref_cnt_q, ref_cnt_d;
    logic             init_req_q, init_req_d;
    logic             init_done_q, init_done_d;
    logic             precharge_q, precharge_d;
    logic             refresh_q, refresh_d;
    logic             load_mode_q, load_mode_d;
    logic             nop_q, nop_d, reada_q, reada_d, writea_q, writea_d;
    logic [ASIZE-1:0] saddr_q, saddr_d;
    logic             cm_ack_dly_q, cm_ack_dly_d;
    logic             cmd_ack_q, cmd_ack_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [PW-1:0]    pend_q, pend_d;
    logic             step_hit_s;
    logic             expiry_s;

    // Init sequencer: power-up wait, then one command every INIT_STEP cycles.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        step_cnt_d  = step_cnt_q;
        ref_cnt_d   = ref_cnt_q;
        init_req_d  = init_req_q;
        init_done_d = init_done_q;
        precharge_d = 1'b0;
        refresh_d   = 1'b0;
        load_mode_d = 1'b0;
        // Step count starts at 1 in the first cycle after INIT_REQ falls.
        // A count of INIT_STEP therefore lands the pulse exactly INIT_STEP cycles later.
        step_hit_s  = (step_cnt_q == SW'(INIT_STEP));
        case (state_q)
            S_WAIT: begin
                if (!init_req_q) begin
                    init_req_d = 1'b1;
                    wait_cnt_d = WW'(1);
                end else if (INIT_ACK || (wait_cnt_q == WW'(INIT_PER))) begin
                    init_req_d = 1'b0;
                    step_cnt_d = SW'(1);
                    state_d    = S_PRE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_PRE: begin
                if (step_hit_s) begin
                    precharge_d = 1'b1;
                    step_cnt_d  = SW'(1);
                    ref_cnt_d   = RW'(0);
                    state_d     = S_REF;
                end else begin
                    step_cnt_d  = step_cnt_q + SW'(1);
                end
            end
            S_REF: begin
                if (step_hit_s) begin
                    refresh_d  = 1'b1;
                    step_cnt_d = SW'(1);
                    if (ref_cnt_q == RW'(INIT_REFS - 1)) begin
                        state_d   = S_LMR;
                    end else begin
                        ref_cnt_d = ref_cnt_q + RW'(1);
                    end
                end else begin
                    step_cnt_d = step_cnt_q + SW'(1);
                end
            end
            S_LMR: begin
                if (step_hit_s) begin
                    load_mode_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    step_cnt_d  = step_cnt_q + SW'(1);
                end
            end
            S_DONE: begin
                init_done_d = 1'b1;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // Host side: one-cycle command decode, address alignment and ack edge detect.
    always_comb begin
        nop_d        = (CMD == 3'b000);
        reada_d      = (CMD == 3'b001) && init_done_q;
        writea_d     = (CMD == 3'b010) && init_done_q;
        saddr_d      = ADDR;
        cm_ack_dly_d = CM_ACK;
        cmd_ack_d    = CM_ACK && !cm_ack_dly_q;
    end

    // Refresh timer and owed-refresh tracking.
    always_comb begin
        // Expire on the cycle the count would reach zero.
        // This makes the refresh period exactly REF_PER cycles.
        expiry_s = init_done_q && (timer_q == TW'(1));
`ifdef REF_POSTPONE_EN
        if (!init_done_q || expiry_s) begin
            timer_d = TW'(REF_PER);
        end else begin
            timer_d = timer_q - TW'(1);
        end
        case ({expiry_s, REF_ACK})
            2'b10:   pend_d = (pend_q == PW'(MAX_PEND)) ? pend_q : pend_q + PW'(1);
            2'b01:   pend_d = (pend_q == PW'(0)) ? pend_q : pend_q - PW'(1);
            default: pend_d = pend_q;
        endcase
`else
        if (!init_done_q || REF_ACK || expiry_s) begin
            timer_d = TW'(REF_PER);
        end else begin
            timer_d = timer_q - TW'(1);
        end
        // Only bit 0 of the pending register can ever be set.
        // A completed refresh wins over a coincident expiry.
        if (REF_ACK) begin
            pend_d = PW'(0);
        end else if (expiry_s) begin
            pend_d = PW'(1);
        end else begin
            pend_d = pend_q;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_WAIT;
            wait_cnt_q   <= '0;
            step_cnt_q   <= '0;
            ref_cnt_q    <= '0;
            init_req_q   <= 1'b0;
            init_done_q  <= 1'b0;
            precharge_q  <= 1'b0;
            refresh_q    <= 1'b0;
            load_mode_q  <= 1'b0;
            nop_q        <= 1'b0;
            reada_q      <= 1'b0;
            writea_q     <= 1'b0;
            saddr_q      <= '0;
            cm_ack_dly_q <= 1'b0;
            cmd_ack_q    <= 1'b0;
            timer_q      <= TW'(REF_PER);
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            step_cnt_q   <= step_cnt_d;
            ref_cnt_q    <= ref_cnt_d;
            init_req_q   <= init_req_d;
            init_done_q  <= init_done_d;
            precharge_q  <= precharge_d;
            refresh_q    <= refresh_d;
            load_mode_q  <= load_mode_d;
            nop_q        <= nop_d;
            reada_q      <= reada_d;
            writea_q     <= writea_d;
            saddr_q      <= saddr_d;
            cm_ack_dly_q <= cm_ack_dly_d;
            cmd_ack_q    <= cmd_ack_d;
            timer_q      <= timer_d;
            pend_q       <= pend_d;
        end
    end

    assign NOP       = nop_q;
    assign READA     = reada_q;
    assign WRITEA    = writea_q;
    assign REFRESH   = refresh_q;
    assign PRECHARGE = precharge_q;
    assign LOAD_MODE = load_mode_q;
    assign SADDR     = saddr_q;
    assign INIT_REQ  = init_req_q;
    assign INIT_DONE = init_done_q;
    assign CMD_ACK   = cmd_ack_q;
    assign REF_PEND  = pend_q;
    assign REF_REQ   = (pend_q != PW'(0));
`ifdef REF_POSTPONE_EN
    assign REF_URGENT = (pend_q >= PW'(MAX_PEND - 1));
`else
    assign REF_URGENT = 1'b0;
`endif

endmodule
